weight_fetch_seq: RTL

//  Upstream sequencer for the 3-channel weight ROM. After a start pulse, it walks every tap of

---
 rtl/weight_fetch_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/weight_fetch_seq.sv
// weight_fetch_seq: walks every tap of every filter, driving the 3-channel weight ROM reads and a
// valid/ready sideband stream aligned with the ROM output register. Optional macro: WEIGHT_FETCH_CH_MASK_EN.
module weight_fetch_seq #(
   parameter int ROM_ADDR_BITS = 10,
   parameter int KERNEL_TAPS   = 9,
   parameter int NUM_FILTERS   = 8,
   parameter int BASE_ADDR     = 0,
   localparam int TAP_W = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1,
   localparam int FIL_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
`ifdef WEIGHT_FETCH_CH_MASK_EN
   input  logic [2:0]                    ch_mask,
`endif
   output logic                          busy,
   output logic                          done,
   output logic [2:0]                    rom_en,
   output logic [2:0][ROM_ADDR_BITS-1:0] rom_addr,
   output logic                          w_valid,
   input  logic                          w_ready,
   output logic [TAP_W-1:0]              w_tap,
   output logic [FIL_W-1:0]              w_filter,
   output logic                          w_last_tap,
   output logic                          w_last
);

   localparam logic [ROM_ADDR_BITS-1:0] BASE_A   = ROM_ADDR_BITS'(BASE_ADDR);
   localparam logic [TAP_W-1:0]         LAST_TAP = TAP_W'(KERNEL_TAPS - 1);
   localparam logic [FIL_W-1:0]         LAST_FIL = FIL_W'(NUM_FILTERS - 1);

   generate
      if (BASE_ADDR + NUM_FILTERS * KERNEL_TAPS > 2 ** ROM_ADDR_BITS) begin : g_cfg_chk
         $error("weight_fetch_seq: filter bank does not fit in the ROM address space");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [TAP_W-1:0]         tap_q, tap_d;
   logic [FIL_W-1:0]         filter_q, filter_d;
   logic [ROM_ADDR_BITS-1:0] addr_q, addr_d;
   logic                     w_valid_q, w_valid_d;
   logic [TAP_W-1:0]         w_tap_q, w_tap_d;
   logic [FIL_W-1:0]         w_filter_q, w_filter_d;
   logic                     w_last_tap_q, w_last_tap_d;
   logic                     w_last_q, w_last_d;
   logic [2:0]               ch_mask_q, ch_mask_d;
   logic                     issue_s;
   logic                     last_issue_s;
   logic                     done_s;

   // Next-state, counter walk and stream register updates.
   always_comb begin
      state_d      = state_q;
      tap_d        = tap_q;
      filter_d     = filter_q;
      addr_d       = addr_q;
      w_valid_d    = w_valid_q;
      w_tap_d      = w_tap_q;
      w_filter_d   = w_filter_q;
      w_last_tap_d = w_last_tap_q;
      w_last_d     = w_last_q;
      ch_mask_d    = ch_mask_q;
      issue_s      = 1'b0;
      done_s       = 1'b0;
      last_issue_s = (tap_q == LAST_TAP) && (filter_q == LAST_FIL);

      case (state_q)
         S_IDLE: begin
            addr_d = BASE_A;
            if (start) begin
               state_d  = S_RUN;
               tap_d    = {TAP_W{1'b0}};
               filter_d = {FIL_W{1'b0}};
`ifdef WEIGHT_FETCH_CH_MASK_EN
               ch_mask_d = ch_mask;
`else
               ch_mask_d = 3'b111;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            issue_s = !w_valid_q || w_ready;
            if (issue_s) begin
               // Running address replaces BASE + filter*KERNEL_TAPS + tap.
               addr_d = addr_q + ROM_ADDR_BITS'(1);
               if (tap_q == LAST_TAP) begin
                  tap_d    = {TAP_W{1'b0}};
                  filter_d = filter_q + FIL_W'(1);
               end else begin
                  tap_d = tap_q + TAP_W'(1);
               end
               if (last_issue_s) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            if (w_valid_q && w_ready && w_last_q) begin
               state_d = S_IDLE;
               done_s  = 1'b1;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Sideband is captured from the issue-time counters so it lines up with the ROM data.
      if (issue_s) begin
         w_valid_d    = 1'b1;
         w_tap_d      = tap_q;
         w_filter_d   = filter_q;
         w_last_tap_d = (tap_q == LAST_TAP);
         w_last_d     = last_issue_s;
      end else if (w_ready) begin
         w_valid_d = 1'b0;
      end else begin
         w_valid_d = w_valid_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counters, address and stream registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_q        <= {TAP_W{1'b0}};
         filter_q     <= {FIL_W{1'b0}};
         addr_q       <= BASE_A;
         w_valid_q    <= 1'b0;
         w_tap_q      <= {TAP_W{1'b0}};
         w_filter_q   <= {FIL_W{1'b0}};
         w_last_tap_q <= 1'b0;
         w_last_q     <= 1'b0;
         ch_mask_q    <= 3'b111;
      end else begin
         tap_q        <= tap_d;
         filter_q     <= filter_d;
         addr_q       <= addr_d;
         w_valid_q    <= w_valid_d;
         w_tap_q      <= w_tap_d;
         w_filter_q   <= w_filter_d;
         w_last_tap_q <= w_last_tap_d;
         w_last_q     <= w_last_d;
         ch_mask_q    <= ch_mask_d;
      end
   end

   // ROM enables stay combinational so the ROM captures the address at the issuing edge.
   assign rom_en     = {3{issue_s}} & ch_mask_q;
   assign rom_addr   = {3{addr_q}};
   assign busy       = (state_q != S_IDLE);
   assign done       = done_s;
   assign w_valid    = w_valid_q;
   assign w_tap      = w_tap_q;
   assign w_filter   = w_filter_q;
   assign w_last_tap = w_last_tap_q;
   assign w_last     = w_last_q;

endmodule
